toggle_lane_checker: RTL
========================

// Module: toggle_lane_checker
// PURPOSE
//  Receive-side checker for a bank of free-running 1-bit toggle lanes (each lane inverts every cycle
//  after a common synchronous reset). Verifies every lane toggles each cycle and stays in phase with
//  lane 0. Reports lock, per-lane sticky errors and a saturating error count. Sits at the consumer end
//  of the toggle-lane bank in test/bring-up designs.
// PARAMETERS
//  N_LANES     32  number of monitored lanes (>=2)
//  ERR_CNT_W   16  width of saturating error counter
//  LOCK_CYCLES 4   consecutive all-good samples required to enter CHECK (>=1)
// PORTS
//  c          in   1          clock; all logic on posedge
//  rn         in   1          reset, asynchronous, active-low
//  en         in   1          checker enable; 0 forces IDLE
//  clr        in   1          sync clear of err_cnt, err_lanes (and log, if built)
//  a          in   N_LANES    toggle lanes under test (synchronous to c)
//  locked     out  1          1 while FSM in CHECK
//  err        out  1          1-cycle pulse per cycle with >=1 bad lane while in CHECK
//  err_lanes  out  N_LANES    sticky OR of bad lanes seen in CHECK
//  err_cnt    out  ERR_CNT_W  count of err pulses, saturating at all-ones
//  state_o    out  2          FSM state encoding (tlc_pkg::state_t)
// BEHAVIOUR
//  - Reset (rn=0, async): every register and output 0; FSM=IDLE.
//  - Input stage: a_q <= a; a_qq <= a_q. Lane j bad when (a_q[j]==a_qq[j]) || (a_q[j]!=a_q[0]);
//    comparison valid only when a_qq holds a sample taken with en=1 (valid flag v, 2-stage).
//  - bad vector computed from a_q/a_qq, registered into err/err_lanes/err_cnt: a faulty sample on a at
//    edge k shows on err after edge k+2 (2-cycle latency).
//  - FSM: IDLE -(en)-> SYNC. SYNC: good_cnt++ on each valid all-good sample, reset to 0 on any bad;
//    good_cnt==LOCK_CYCLES -> CHECK. CHECK: any bad lane -> err pulse, err_lanes|=bad, err_cnt++
//    (sat), next state SYNC with good_cnt=0 (locked drops same edge as err rises).
//    en=0 in any state -> IDLE next edge, v cleared; counters/err_lanes hold.
//  - Errors outside CHECK never touch err, err_lanes, err_cnt.
//  - clr has priority: clr in same cycle as an error -> err_cnt=0, err_lanes=0, err still pulses,
//    FSM still leaves CHECK.
//  - err_cnt at all-ones stays all-ones; no wrap.
// CONFIGURATION
//  TOGGLE_LANE_CHECKER_ERR_LOG_EN defined: extra outputs first_valid (1) and first_lane
//   ($clog2(N_LANES)); on first err pulse since reset/clr capture lowest-index bad lane, set
//   first_valid; later errors do not overwrite; clr clears both. Not defined: ports and logic absent.
// STRUCTURE
//  - Package tlc_pkg: state_t enum {IDLE=2'd0, SYNC=2'd1, CHECK=2'd2}; lowest-set-bit function.
//  - Sub-module tlc_lane (one per lane via generate loop gen_lane): a_q/a_qq regs + bad_o;
//    top holds FSM, good_cnt, counters, optional log.
// TESTING
//  1. rn release, en=1, 32 clean toggling lanes -> locked=1 within LOCK_CYCLES+3 cycles; after 100
//     cycles err_cnt=0, err_lanes=0.
//  2. In CHECK hold lane 5 for one cycle -> single err pulse 2 cycles later, err_lanes=32'h0000_0020,
//     err_cnt=1, locked=0, relock after 4 good samples.
//  3. Lane 31 inverted vs lane 0 from start -> never locked, state_o=SYNC, err_cnt=0, err_lanes=0.
//  4. ERR_CNT_W=2, inject 5 separated errors (relock between) -> err_cnt=2'b11, no wrap.
//  5. rn low mid-CHECK -> all outputs 0 immediately; clr coincident with error -> err_cnt=0, err=1.
//  6. ERR_LOG_EN: lanes 7 and 3 bad same cycle, later lane 1 -> first_lane=3, first_valid=1.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared types and helpers for the toggle-lane checker.
//   state_t    : FSM encoding exported on state_o (IDLE=0, SYNC=1, CHECK=2)
//   MAX_LANES  : widest lane vector lowest_set() can scan
//   lowest_set : index of the lowest set bit (0 when no bit is set)
package tlc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // N_LANES of any instance must not exceed this.
    localparam int unsigned MAX_LANES = 256;

    function automatic int unsigned lowest_set(input logic [MAX_LANES-1:0] v);
        int unsigned idx;
        idx = 0;
        // Scan downwards so the last hit is the lowest index.
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tlc_lane.sv
// One monitored toggle lane: two-deep sample history plus a repeat detector.
// Ports:
//   clk_i  : clock, posedge
//   rst_ni : asynchronous active-low reset
//   a_i    : raw lane input
//   a_q_o  : most recent sample (phase comparison against lane 0 is done in the top)
//   rep_o  : 1 when the two most recent samples are equal, i.e. the lane failed to toggle
module tlc_lane (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic a_i,
    output logic a_q_o,
    output logic rep_o
);

    logic a_q;
    logic a_qq;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q  <= 1'b0;
            a_qq <= 1'b0;
        end else begin
            a_q  <= a_i;
            a_qq <= a_q;
        end
    end

    assign a_q_o = a_q;
    assign rep_o = (a_q == a_qq);

endmodule

// File: rtl/toggle_lane_checker.sv
// Receive-side checker for a bank of free-running toggle lanes. Every lane must invert each
// cycle and stay in phase with lane 0. After LOCK_CYCLES consecutive clean samples the checker
// locks (CHECK); any bad sample while locked pulses err, records the lanes, bumps a saturating
// counter and drops back to SYNC.
// Optional build macro: TOGGLE_LANE_CHECKER_ERR_LOG_EN adds first_valid/first_lane, which log
// the lowest-index bad lane of the first err pulse since reset or clr.
// Ports:
//   c           : clock, posedge
//   rn          : asynchronous active-low reset
//   en          : checker enable; 0 forces IDLE and invalidates the sample history
//   clr         : synchronous clear of err_cnt, err_lanes (and the log)
//   a           : lanes under test
//   locked      : 1 while in CHECK
//   err         : one-cycle pulse per bad sample seen in CHECK
//   err_lanes   : sticky OR of bad lanes seen in CHECK
//   err_cnt     : saturating count of err pulses
//   state_o     : FSM state (tlc_pkg::state_t)
//   first_valid : (log build) a first error has been logged
//   first_lane  : (log build) lowest bad lane of that first error
module toggle_lane_checker
    import tlc_pkg::*;
#(
    parameter int unsigned N_LANES     = 32,
    parameter int unsigned ERR_CNT_W   = 16,
    parameter int unsigned LOCK_CYCLES = 4
) (
    input  logic                   c,
    input  logic                   rn,
    input  logic                   en,
    input  logic                   clr,
    input  logic [N_LANES-1:0]     a,
    output logic                   locked,
    output logic                   err,
    output logic [N_LANES-1:0]     err_lanes,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic [1:0]             state_o
`ifdef TOGGLE_LANE_CHECKER_ERR_LOG_EN
    ,
    output logic                   first_valid,
    output logic [$clog2(N_LANES)-1:0] first_lane
`endif
);

    localparam int unsigned GOOD_W     = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned LANE_IDX_W = $clog2(N_LANES);

    logic [N_LANES-1:0]   a_q;
    logic [N_LANES-1:0]   rep;
    logic [N_LANES-1:0]   bad;
    logic                 any_bad;
    logic                 valid;
    logic                 err_set;

    logic                 v1_q;
    logic                 v2_q;
    state_t               state_q;
    logic [GOOD_W-1:0]    good_cnt_q;
    logic                 err_q;
    logic [N_LANES-1:0]   err_lanes_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    for (genvar j = 0; j < N_LANES; j++) begin : gen_lane
        tlc_lane u_lane (
            .clk_i  (c),
            .rst_ni (rn),
            .a_i    (a[j]),
            .a_q_o  (a_q[j]),
            .rep_o  (rep[j])
        );
    end

    // A lane is bad if it did not toggle or disagrees with lane 0's current sample.
    assign bad     = rep | (a_q ^ {N_LANES{a_q[0]}});
    assign any_bad = |bad;
    // v2_q is set only when both samples in the history were taken with en high.
    assign valid   = v2_q;
    assign err_set = en && (state_q == CHECK) && valid && any_bad;

    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            state_q     <= IDLE;
            good_cnt_q  <= '0;
            err_q       <= 1'b0;
            err_lanes_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            v1_q  <= en;
            v2_q  <= v1_q & en;
            err_q <= err_set;

            if (!en) begin
                state_q    <= IDLE;
                good_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q    <= SYNC;
                        good_cnt_q <= '0;
                    end
                    SYNC: begin
                        if (valid) begin
                            if (any_bad) begin
                                good_cnt_q <= '0;
                            end else if (good_cnt_q + 1'b1 == GOOD_W'(LOCK_CYCLES)) begin
                                state_q    <= CHECK;
                                good_cnt_q <= '0;
                            end else begin
                                good_cnt_q <= good_cnt_q + 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        if (err_set) begin
                            state_q    <= SYNC;
                            good_cnt_q <= '0;
                        end
                    end
                    default: begin
                        state_q    <= IDLE;
                        good_cnt_q <= '0;
                    end
                endcase
            end

            // clr wins over a coincident error; err itself still pulses.
            if (clr) begin
                err_lanes_q <= '0;
                err_cnt_q   <= '0;
            end else if (err_set) begin
                err_lanes_q <= err_lanes_q | bad;
                if (err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
            end
        end
    end

    assign locked    = (state_q == CHECK);
    assign err       = err_q;
    assign err_lanes = err_lanes_q;
    assign err_cnt   = err_cnt_q;
    assign state_o   = state_q;

`ifdef TOGGLE_LANE_CHECKER_ERR_LOG_EN
    logic                  first_valid_q;
    logic [LANE_IDX_W-1:0] first_lane_q;

    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            first_valid_q <= 1'b0;
            first_lane_q  <= '0;
        end else if (clr) begin
            first_valid_q <= 1'b0;
            first_lane_q  <= '0;
        end else if (err_set && !first_valid_q) begin
            first_valid_q <= 1'b1;
            first_lane_q  <= LANE_IDX_W'(lowest_set(MAX_LANES'(bad)));
        end
    end

    assign first_valid = first_valid_q;
    assign first_lane  = first_lane_q;
`endif

endmodule
